// File: rtl/alu_exec_sequencer_if.sv
// Instruction handshake and ALU operand/result bundle between the execute-stage
// sequencer (slave) and its upstream decoder plus the combinational ALU (master).
interface alu_exec_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        use_imm;
    logic        wb_en;
    logic        flags_en;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;

    modport master (
        output instr_valid, opcode, rdest, rsrc, imm, use_imm, wb_en, flags_en,
        output alu_c, alu_flags,
        input  instr_ready, alu_a, alu_b, alu_opcode
    );

    modport slave (
        input  instr_valid, opcode, rdest, rsrc, imm, use_imm, wb_en, flags_en,
        input  alu_c, alu_flags,
        output instr_ready, alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: snapshots operands into the ALU, waits ALU_WAIT cycles,
// then writes C back to the register file and Flags to the PSR.
//
// state | meaning
// IDLE  | ready for an instruction; accept edge loads operands and wait counter
// EXEC  | operands held for the ALU; counter reaching zero is the writeback edge
module alu_exec_sequencer #(
    parameter int ALU_WAIT = 1,
    parameter int NREGS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_exec_sequencer_if.slave   bus,
    output logic [4:0]            psr,
    output logic                  done,
    input  logic [3:0]            dbg_addr,
    output logic [15:0]           dbg_data
);
    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(ALU_WAIT - 1);

    state_t      state, state_nxt;
    logic        accept;
    logic        wb_fire;
    logic [2:0]  cnt;
    logic [3:0]  rdest_q;
    logic        wb_en_q;
    logic        flags_en_q;
    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic [7:0]  alu_opcode_q;
    logic [15:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wb_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0) begin
                    wb_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured once at the accept edge; upstream fields are free to
    // change afterwards without disturbing the ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            rdest_q      <= '0;
            wb_en_q      <= 1'b0;
            flags_en_q   <= 1'b0;
            cnt          <= '0;
            done         <= 1'b0;
            psr          <= '0;
        end else begin
            done <= wb_fire;
            if (accept) begin
                alu_a_q      <= regs[bus.rdest];
                alu_b_q      <= bus.use_imm ? bus.imm : regs[bus.rsrc];
                alu_opcode_q <= bus.opcode;
                rdest_q      <= bus.rdest;
                wb_en_q      <= bus.wb_en;
                flags_en_q   <= bus.flags_en;
                cnt          <= CNT_LOAD;
            end else if (state == EXEC && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (wb_fire && flags_en_q) begin
                psr <= bus.alu_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire && wb_en_q) begin
            regs[rdest_q] <= bus.alu_c;
        end
    end

    assign bus.instr_ready = (state == IDLE) && !reset;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign dbg_data        = regs[dbg_addr];
endmodule
